// File: rtl/uart_rx_deframer_if.sv
// Character hand-off channel between the UART receive deframer and its consumer.
// The master drives characters and status pulses; the slave returns rx_ready.
interface uart_rx_deframer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled, 2-flop synchronised rxd; char ready 1 clk after last stop sample.
// Holds one character under valid/ready; a char completing while the slot is full is dropped (overrun pulse).
module uart_rx_deframer #(
    parameter int DIV_W = 16,
    parameter int OVS   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop_bits,
    input  logic             rxd,
    uart_rx_deframer_if.master rx
);
    localparam logic [3:0] SC_MID  = 4'(OVS / 2 - 1);
    localparam logic [3:0] SC_LAST = 4'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, rxs_q;
    logic [DIV_W-1:0] tcnt_q, tcnt_d;
    logic [3:0]       sc_q, sc_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             pbit_q, pbit_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic             ferr_q, ferr_d;
    logic             stop1_q, stop1_d;
    logic             cmpl_q, cmpl_d;
    logic [1:0]       nbits_q, nbits_d;
    logic             pen_q, pen_d;
    logic             podd_q, podd_d;
    logic             sb_q, sb_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             perr_out_q, perr_out_d;
    logic             ferr_out_q, ferr_out_d;
    logic             brk_q, brk_d;
    logic             ovr_q, ovr_d;

    logic [DIV_W-1:0] reload;
    logic             tick;
    logic             start_frame;
    logic             is_brk;
    logic [2:0]       last_bit;

    assign reload   = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    assign tick     = (tcnt_q == '0);
    assign last_bit = {1'b0, nbits_q} + 3'd4;
    assign is_brk   = (shreg_q == 8'h00) && !(pen_q && pbit_q) && !stop1_q;

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tick ? reload : tcnt_q - DIV_W'(1);
        sc_d        = sc_q;
        bcnt_d      = bcnt_q;
        shreg_d     = shreg_q;
        pbit_d      = pbit_q;
        stop_cnt_d  = stop_cnt_q;
        ferr_d      = ferr_q;
        stop1_d     = stop1_q;
        cmpl_d      = 1'b0;
        nbits_d     = nbits_q;
        pen_d       = pen_q;
        podd_d      = podd_q;
        sb_d        = sb_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        perr_out_d  = perr_out_q;
        ferr_out_d  = ferr_out_q;
        brk_d       = 1'b0;
        ovr_d       = 1'b0;
        start_frame = 1'b0;

        if (rx_valid_q && rx.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == SC_MID) begin
                        if (rxs_q) begin
                            state_d = IDLE;
                        end else begin
                            sc_d    = 4'd0;
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == SC_LAST) begin
                        shreg_d[bcnt_q] = rxs_q;
                        bcnt_d          = bcnt_q + 3'd1;
                        if (bcnt_q == last_bit) begin
                            state_d = pen_q ? PARITY : STOP;
                        end
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == SC_LAST) begin
                        pbit_d  = rxs_q;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                end
                if (cmpl_q) begin
                    if (is_brk) begin
                        brk_d   = 1'b1;
                        state_d = BRK_WAIT;
                    end else begin
                        if (rx_valid_q && !rx.rx_ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            rx_data_d  = shreg_q;
                            perr_out_d = pen_q && ((^shreg_q ^ pbit_q) != podd_q);
                            ferr_out_d = ferr_q;
                            rx_valid_d = 1'b1;
                        end
                        // A low stop bit may be the start bit of the next character.
                        if (ferr_q && !rxs_q) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (tick && sc_q == SC_LAST) begin
                    if (!stop_cnt_q) begin
                        stop1_d = rxs_q;
                        ferr_d  = !rxs_q;
                        if (sb_q) begin
                            stop_cnt_d = 1'b1;
                        end else begin
                            cmpl_d = 1'b1;
                        end
                    end else begin
                        ferr_d = ferr_q | !rxs_q;
                        cmpl_d = 1'b1;
                    end
                end
            end
            BRK_WAIT: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reloading the tick divider on the start edge centres every sample in its bit.
        if (start_frame) begin
            state_d    = START;
            tcnt_d     = reload;
            sc_d       = 4'd0;
            bcnt_d     = 3'd0;
            shreg_d    = 8'h00;
            pbit_d     = 1'b0;
            stop_cnt_d = 1'b0;
            ferr_d     = 1'b0;
            stop1_d    = 1'b1;
            nbits_d    = data_bits;
            pen_d      = parity_en;
            podd_d     = parity_odd;
            sb_d       = stop_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            tcnt_q     <= '0;
            sc_q       <= 4'd0;
            bcnt_q     <= 3'd0;
            shreg_q    <= 8'h00;
            pbit_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
            ferr_q     <= 1'b0;
            stop1_q    <= 1'b1;
            cmpl_q     <= 1'b0;
            nbits_q    <= 2'd0;
            pen_q      <= 1'b0;
            podd_q     <= 1'b0;
            sb_q       <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            tcnt_q     <= tcnt_d;
            sc_q       <= sc_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
            pbit_q     <= pbit_d;
            stop_cnt_q <= stop_cnt_d;
            ferr_q     <= ferr_d;
            stop1_q    <= stop1_d;
            cmpl_q     <= cmpl_d;
            nbits_q    <= nbits_d;
            pen_q      <= pen_d;
            podd_q     <= podd_d;
            sb_q       <= sb_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx.rx_data    = rx_data_q;
    assign rx.rx_valid   = rx_valid_q;
    assign rx.parity_err = perr_out_q;
    assign rx.frame_err  = ferr_out_q;
    assign rx.break_det  = brk_q;
    assign rx.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: serial frames driven on rxd, outputs compared to hand-computed values.
module tb_uart_rx_deframer;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] divisor = 16'd4;
    logic [1:0]  data_bits = 2'd3;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        stop_bits = 1'b0;
    logic        rxd = 1'b1;

    uart_rx_deframer_if bus ();

    uart_rx_deframer #(.DIV_W(16), .OVS(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .divisor    (divisor),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop_bits  (stop_bits),
        .rxd        (rxd),
        .rx         (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int cap_cnt = 0;
    int brk_cnt = 0;
    int ovr_cnt = 0;
    int rise_cyc = 0;
    logic [7:0] cap_data = 8'h00;
    logic cap_perr = 1'b0;
    logic cap_ferr = 1'b0;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid && !prev_vld) rise_cyc = cyc;
        prev_vld = bus.rx_valid;
        if (bus.rx_valid && bus.rx_ready) begin
            cap_cnt++;
            cap_data = bus.rx_data;
            cap_perr = bus.parity_err;
            cap_ferr = bus.frame_err;
        end
        if (bus.break_det) brk_cnt++;
        if (bus.overrun) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pb,
                              input bit s1, input bit s2, input bit two, input int bclk);
        drive_bit(1'b0, bclk);
        for (int i = 0; i < nb; i++) drive_bit(d[i], bclk);
        if (pen) drive_bit(pb, bclk);
        drive_bit(s1, bclk);
        if (two) drive_bit(s2, bclk);
    endtask

    int start_cyc;
    int lat;
    int snap;

    initial begin
        bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(bus.rx_valid), 0);
        chk("rst_data", 32'(bus.rx_data), 0);
        chk("rst_perr", 32'(bus.parity_err), 0);
        chk("rst_ferr", 32'(bus.frame_err), 0);
        chk("rst_brk", 32'(bus.break_det), 0);
        chk("rst_ovr", 32'(bus.overrun), 0);
        drive_bit(1'b1, 64);

        // 8N1 0xA5 at 64 clk/bit with the consumer always ready
        start_cyc = cyc;
        send_frame(8'hA5, 8, 0, 0, 1, 1, 0, 64);
        drive_bit(1'b1, 128);
        lat = rise_cyc - start_cyc;
        chk("a5_count", 32'(cap_cnt), 1);
        chk("a5_data", 32'(cap_data), 32'hA5);
        chk("a5_perr", 32'(cap_perr), 0);
        chk("a5_ferr", 32'(cap_ferr), 0);
        chk("a5_latency_ok", 32'(lat >= 600 && lat <= 616), 1);
        chk("a5_consumed", 32'(bus.rx_valid), 0);

        // false start: 20 clk low pulse
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 128);
        chk("fs_novalid", 32'(bus.rx_valid), 0);
        chk("fs_count", 32'(cap_cnt), 1);
        send_frame(8'h3C, 8, 0, 0, 1, 1, 0, 64);
        drive_bit(1'b1, 128);
        chk("3c_count", 32'(cap_cnt), 2);
        chk("3c_data", 32'(cap_data), 32'h3C);

        // 7E1 parity checks, consumer held off
        bus.rx_ready = 1'b0;
        data_bits = 2'd2; parity_en = 1'b1; parity_odd = 1'b0;
        send_frame(8'h41, 7, 1, 1, 1, 1, 0, 64);
        drive_bit(1'b1, 128);
        chk("7e1_bad_valid", 32'(bus.rx_valid), 1);
        chk("7e1_bad_data", 32'(bus.rx_data), 32'h41);
        chk("7e1_bad_perr", 32'(bus.parity_err), 1);
        chk("7e1_bad_ferr", 32'(bus.frame_err), 0);
        bus.rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.rx_ready = 1'b0;
        chk("7e1_consumed", 32'(bus.rx_valid), 0);
        send_frame(8'h41, 7, 1, 0, 1, 1, 0, 64);
        drive_bit(1'b1, 128);
        chk("7e1_ok_data", 32'(bus.rx_data), 32'h41);
        chk("7e1_ok_perr", 32'(bus.parity_err), 0);
        bus.rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.rx_ready = 1'b0;

        // 8N2 with low second stop, running straight into a 12-bit break
        data_bits = 2'd3; parity_en = 1'b0; stop_bits = 1'b1;
        snap = brk_cnt;
        send_frame(8'h55, 8, 0, 0, 1, 0, 1, 64);
        drive_bit(1'b0, 12 * 64);
        drive_bit(1'b1, 128);
        chk("8n2_data", 32'(bus.rx_data), 32'h55);
        chk("8n2_ferr", 32'(bus.frame_err), 1);
        chk("brk_count", 32'(brk_cnt - snap), 1);
        chk("brk_valid_kept", 32'(bus.rx_valid), 1);
        chk("brk_no_ovr", 32'(ovr_cnt), 0);
        bus.rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'hC3, 8, 0, 0, 1, 1, 1, 64);
        drive_bit(1'b1, 128);
        chk("c3_data", 32'(cap_data), 32'hC3);
        chk("c3_ferr", 32'(cap_ferr), 0);

        // overrun: two chars with no consumer
        bus.rx_ready = 1'b0;
        stop_bits = 1'b0;
        send_frame(8'h11, 8, 0, 0, 1, 1, 0, 64);
        drive_bit(1'b1, 128);
        send_frame(8'h22, 8, 0, 0, 1, 1, 0, 64);
        drive_bit(1'b1, 128);
        chk("ovr_count", 32'(ovr_cnt), 1);
        chk("ovr_data_kept", 32'(bus.rx_data), 32'h11);
        chk("ovr_valid", 32'(bus.rx_valid), 1);
        bus.rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.rx_ready = 1'b0;
        chk("ovr_consumed", 32'(bus.rx_valid), 0);
        chk("ovr_data_after", 32'(bus.rx_data), 32'h11);

        // reset during the high data bits of 0xF0
        snap = cap_cnt;
        fork
            send_frame(8'hF0, 8, 0, 0, 1, 1, 0, 64);
            begin
                repeat (5 * 64 + 32) @(negedge clk);
                rstn = 1'b1;
                @(negedge clk);
                rstn = 1'b0;
                chk("mid_rst_data", 32'(bus.rx_data), 0);
                chk("mid_rst_valid", 32'(bus.rx_valid), 0);
                chk("mid_rst_flags", 32'({bus.parity_err, bus.frame_err, bus.break_det, bus.overrun}), 0);
            end
        join
        drive_bit(1'b1, 128);
        chk("mid_rst_no_char", 32'(bus.rx_valid), 0);
        divisor = 16'd0;
        bus.rx_ready = 1'b1;
        send_frame(8'h0F, 8, 0, 0, 1, 1, 0, 16);
        drive_bit(1'b1, 64);
        chk("div0_count", 32'(cap_cnt - snap), 1);
        chk("div0_data", 32'(cap_data), 32'h0F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side deframer of the UART UVC DUT path. Consumes the serial `rxd` line driven by the bus interface and produces parallel characters with error flags.
- Uses a 16x oversampling tick generated internally from a programmable divisor.
- Hands characters to the downstream register/FIFO stage over a valid/ready handshake.

Parameters:
- DIV_W, 16, width of the baud divisor input.
- OVS, 16, oversampling ticks per bit (fixed at 16; other values unsupported).

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous reset, active-high (1 = reset)
- divisor  input  DIV_W  clk cycles per oversample tick; 0 treated as 1
- data_bits  input  2  character length: 0=5, 1=6, 2=7, 3=8 bits
- parity_en  input  1  parity bit present
- parity_odd  input  1  1=odd parity, 0=even parity
- stop_bits  input  1  0=one stop bit, 1=two stop bits
- rxd  input  1  asynchronous serial line, idle high
- rx_data  output  8  received character, LSB-aligned, unused upper bits 0
- rx_valid  output  1  rx_data holds an unconsumed character
- rx_ready  input  1  consumer accepts when rx_valid && rx_ready
- parity_err  output  1  parity error flag for the character in rx_data
- frame_err  output  1  a stop bit was sampled 0 for the character in rx_data
- break_det  output  1  one-cycle pulse on break detection
- overrun  output  1  one-cycle pulse when a character is dropped

Behaviour:
- Reset (`rstn`=1 at a clk edge):
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, break_det=0, overrun=0.
  - Synchronizer flops = 1; state=IDLE; all counters = 0.
  - Reset asserted mid-frame aborts the frame; no output is produced.
- Sync: `rxd` passes through 2 flops (reset value 1). All decisions use the synchronized value `rxs`.
- Tick: a down-counter reloads to max(divisor,1)-1 and pulses `tick` for one clk on reaching 0. It runs continuously and is reloaded when a start edge is detected, which aligns sampling to the edge.
- Config (data_bits, parity_en, parity_odd, stop_bits) is latched at start-edge detection. Changes mid-frame take effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT. Sample counter sc runs 0..15 on ticks.
  - IDLE: when rxs=0, clear sc and go to START.
  - START: at sc=7 (bit midpoint), if rxs=1 it is a false start: go to IDLE, no output. Otherwise clear sc and go to DATA.
  - DATA: sample at each sc=15, LSB first, into the shift register. After N bits, go to PARITY if parity_en, else STOP.
  - PARITY: sample at sc=15. perr = (XOR of data bits XOR parity bit) != parity_odd.
  - STOP: sample one or two stop bits at sc=15. ferr = any stop sample is 0.
- Completion: on the clk after the last stop sample:
  - If rx_valid=1 and rx_ready=0: pulse overrun; discard the new character; rx_data and the flags keep their old values.
  - Otherwise: load rx_data, parity_err, frame_err and set rx_valid=1.
- Break: data bits all 0, parity bit 0 (if enabled) and the first stop bit 0:
  - Pulse break_det. No character is loaded and rx_valid is unchanged.
  - Go to BRK_WAIT, which stays until rxs=1 and then returns to IDLE.
- Non-break frame error: after loading, if rxs=0 go to START directly (the low stop bit is treated as a new start), else go to IDLE.
- Handshake:
  - A transfer occurs on a clk where rx_valid && rx_ready.
  - On that transfer, rx_valid clears the next cycle unless a new character completes on the same cycle. In that case the new character loads, rx_valid stays 1 and overrun is not asserted.
  - rx_data and the flags are stable while rx_valid=1 and rx_ready=0.
- Latency: rx_valid rises about (8 + 16*(1+N+P+S-1) + 1) ticks after the start edge, plus 2 clk of synchronizer delay plus 1 clk.

Test Plan:
- divisor=4 (64 clk/bit), 8N1, send 0xA5, rx_ready=1 -> rx_data=0xA5 with parity_err=0 and frame_err=0; rx_valid rises 608±8 clk after the falling edge.
- rxd low for 20 clk then high, divisor=4 -> no rx_valid, FSM returns to IDLE, and a following 0x3C is received correctly.
- 7E1, send 0x41 with parity bit=1 (correct is 0) -> rx_data=0x41, parity_err=1; then 0x41 with parity=0 -> parity_err=0.
- 8N2, send 0x55 with the second stop bit=0 -> rx_data=0x55, frame_err=1. Then rxd low for 12 bit times -> break_det pulses once, rx_valid unchanged, and the next byte 0xC3 is received cleanly after rxd returns high.
- rx_ready=0, send 0x11 then 0x22 -> overrun pulses once at completion of 0x22; rx_data stays 0x11. Set rx_ready=1 -> 0x11 is accepted and rx_valid=0.
- Assert rstn during the DATA state of 0xF0 -> all outputs are 0 the next cycle, and a subsequent 0x0F is received correctly with divisor=0 (treated as 1; 16 clk/bit).
